apu: RTL and testbench
======================

Name: apu

Overview:
- Address Processing Unit bank for the control unit: APU_CNT independent affine address generators.
- Each APU keeps three accumulators: address, stride_x and stride_y.
- Each accumulator is a base plus a running sum of di × coefficient[loop_var], taken from a per-APU formula latched during reset.
- A selector picks which APU's current values and per-cycle deltas drive the outputs.

Parameters:
- BITS, 8: datapath width of coefficients, di, accumulators and outputs.
- LOG_LOOP_CNT, 1: log2 of the number of loop variables; LOOP_CNT = 2**LOG_LOOP_CNT.
- LOG_APU_CNT, 1: log2 of the number of APUs; APU_CNT = 2**LOG_APU_CNT.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  accumulator update enable.
- di  in  BITS  signed (two's complement) step for the active loop variable.
- new_address_formula  in  (LOOP_CNT+1)*BITS*APU_CNT  packed address formulas for all APUs.
- new_stride_x_formula  in  same width  packed stride_x formulas.
- new_stride_y_formula  in  same width  packed stride_y formulas.
- loop_var  in  LOG_LOOP_CNT  index of the loop variable being stepped.
- apu_selector  in  LOG_APU_CNT  APU whose values drive the outputs.
- out  out  6*BITS  packed {addr, stridex, stridey, daddr, dstridex, dstridey}, addr in the MSBs, each field of type apu_output (BITS wide).

Behaviour:
- Formula packing:
  - APU a occupies slice [(LOOP_CNT+1)*BITS*(APU_CNT-1-a) +: (LOOP_CNT+1)*BITS], so APU 0 is most significant.
  - Within a slice, term k sits at [k*BITS +: BITS].
  - Term 0 is the base (constant); term 1+j is the coefficient of loop variable j.
- Formula registers:
  - On every rising clk edge while reset=1, all three formula sets for all APUs are captured from the new_* inputs.
  - They hold while reset=0 and have no asynchronous reset, so reset must span at least one rising edge.
- Accumulators:
  - Each APU has three offset registers: address, stride_x, stride_y.
  - reset=1 asynchronously clears all offsets to 0 and keeps them at 0 while asserted.
- Update:
  - On a rising edge with reset=0 and enable=1, for every APU and every accumulator: offset <= offset + di*coef[loop_var] (coefficient from that accumulator's formula).
  - All APUs update in parallel, independent of apu_selector.
  - enable=0 holds all offsets.
- Current value: base + offset, per accumulator per APU.
- Arithmetic: products and sums truncated modulo 2**BITS; negative di wraps correctly (e.g. di=8'hFE subtracts 2×coef).
- Latency:
  - One cycle: di/loop_var applied before edge N are reflected in addr after edge N.
  - No feedback within the same cycle.
- Outputs (combinational from apu_selector, registers and live inputs):
  - addr, stridex, stridey = current values of APU apu_selector.
  - daddr, dstridex, dstridey = di*coef[loop_var] of the selected APU, i.e. the step that will be applied at the next enabled edge.
  - Changing apu_selector changes outputs without a clock edge.
- During reset: addr/stridex/stridey equal the latched bases; deltas still follow di.
- Reset asserted mid-operation: offsets clear immediately; formulas reload at the next edge.

Decomposition:
- Shared types package: typedef apu_output (logic [BITS-1:0], BITS=8 default).
- Natural sub-module apu_accum, instantiated 3×APU_CNT times. It contains:
  - one formula register (LOOP_CNT+1 terms);
  - one offset register;
  - delta multiply and current-value adder.
- Top level handles:
  - slicing of the new_* buses;
  - output muxing by apu_selector;
  - output concatenation.

Test Plan:
1. Reset load:
   - Stimulus: reset=1 for one edge, enable=1, di=0, loop_var=0; address formulas APU0 {base 0, c0=1, c1=2}, APU1 {0, 3, 4}.
   - Required: addr=0 and APU1 address=0.
2. Single step: reset=0, di=1, loop_var=0, one edge -> addr=1, APU1=3. Then di=0, one edge -> addr=1, APU1=3 (hold).
3. Step on loop_var 0: di=2, one edge -> addr=3, APU1=9, daddr=2 before the edge.
4. Switch loop variable: loop_var=1, di=2, one edge -> addr=7, APU1=17.
5. Negative step and selector:
   - di=8'hFE, one edge -> addr=3, APU1=9.
   - Then apu_selector=1 with no clock edge -> addr=9 within 2 ns.
6. Enable and mid-run reset:
   - enable=0 with di=5 over several edges -> all values unchanged.
   - Assert reset between edges -> offsets return to the bases immediately.
   - Stride formulas exercised likewise, e.g. stride_x formula {base 5, 1, 1}, di=1 -> stridex 5→6.

Source files
------------

// File: rtl/apu_pkg.sv
// -----------------------------------------------------------------------------
// apu_pkg: shared types and helpers for the address processing unit bank.
//   apu_output    : one BITS-wide output field (address, stride or delta).
//   acc_kind_e    : which of the three per-APU accumulators a formula feeds.
//   formula_width : width of one APU's formula slice (base + LOOP_CNT coefs).
// -----------------------------------------------------------------------------
package apu_pkg;

  localparam int APU_BITS = 8;
  localparam int ACC_CNT  = 3;

  typedef logic [APU_BITS-1:0] apu_output;

  typedef enum logic [1:0] {
    ACC_ADDR     = 2'd0,
    ACC_STRIDE_X = 2'd1,
    ACC_STRIDE_Y = 2'd2
  } acc_kind_e;

  function automatic int formula_width(input int bits, input int loop_cnt);
    return (loop_cnt + 1) * bits;
  endfunction

endpackage

// File: rtl/apu_accum.sv
// -----------------------------------------------------------------------------
// apu_accum: one affine accumulator (address, stride_x or stride_y of one APU).
//   value = base + sum of di * coef[loop_var] over all enabled edges.
// Ports:
//   clk         clock, rising edge
//   rst         async active-high: clears the offset; also loads the formula
//               (synchronously, on every edge while high)
//   i_enable    offset update enable
//   i_di        step for the active loop variable (two's complement)
//   i_loop_var  index of the loop variable being stepped
//   i_formula   {coef[LOOP_CNT-1], ..., coef[0], base}, base in the LSBs
//   o_value     base + offset
//   o_delta     di * coef[loop_var], the step applied at the next enabled edge
// -----------------------------------------------------------------------------
module apu_accum
  import apu_pkg::*;
#(
  parameter int BITS         = 8,
  parameter int LOG_LOOP_CNT = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      i_enable,
  input  logic [BITS-1:0]                           i_di,
  input  logic [LOG_LOOP_CNT-1:0]                   i_loop_var,
  input  logic [(2**LOG_LOOP_CNT+1)*BITS-1:0]       i_formula,
  output logic [BITS-1:0]                           o_value,
  output logic [BITS-1:0]                           o_delta
);

  localparam int LOOP_CNT = 2**LOG_LOOP_CNT;
  localparam int FW       = formula_width(BITS, LOOP_CNT);

  logic [FW-1:0]   r_formula;
  logic [BITS-1:0] r_offset;
  logic [BITS-1:0] w_base;
  logic [BITS-1:0] w_coef;
  logic [BITS-1:0] w_delta;
  logic [BITS-1:0] w_coefs [LOOP_CNT];

  // The formula has no asynchronous clear: it is captured on each edge seen
  // while reset is high, so reset must cover at least one rising edge.
  always_ff @(posedge clk) begin
    if (rst) r_formula <= i_formula;
  end

  assign w_base = r_formula[0 +: BITS];

  for (genvar j = 0; j < LOOP_CNT; j++) begin : g_coef
    assign w_coefs[j] = r_formula[(j+1)*BITS +: BITS];
  end

  assign w_coef = w_coefs[i_loop_var];

  // Truncated product: modulo 2**BITS the signed and unsigned results agree,
  // so a negative di subtracts correctly without sign extension.
  assign w_delta = i_di * w_coef;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_offset <= '0;
    end else if (i_enable) begin
      r_offset <= r_offset + w_delta;
    end
  end

  assign o_value = w_base + r_offset;
  assign o_delta = w_delta;

endmodule

// File: rtl/apu.sv
// -----------------------------------------------------------------------------
// apu: bank of APU_CNT affine address generators, each with address,
// stride_x and stride_y accumulators. All APUs step in parallel; the selector
// only chooses which APU is shown on the output.
// Ports:
//   clk, reset                 clock; async active-high reset (also loads
//                              the formulas on each edge while high)
//   enable                     accumulator update enable
//   di                         signed step for the active loop variable
//   new_*_formula              packed formulas, APU 0 in the MSB slice,
//                              term k of a slice at [k*BITS +: BITS]
//   loop_var                   loop variable being stepped
//   apu_selector               APU driving the outputs
//   out                        {addr, stridex, stridey, daddr, dstridex,
//                              dstridey}, addr in the MSBs
// -----------------------------------------------------------------------------
module apu
  import apu_pkg::*;
#(
  parameter int BITS         = 8,
  parameter int LOG_LOOP_CNT = 1,
  parameter int LOG_APU_CNT  = 1
) (
  input  logic                                                    clk,
  input  logic                                                    reset,
  input  logic                                                    enable,
  input  logic [BITS-1:0]                                         di,
  input  logic [(2**LOG_LOOP_CNT+1)*BITS*(2**LOG_APU_CNT)-1:0]    new_address_formula,
  input  logic [(2**LOG_LOOP_CNT+1)*BITS*(2**LOG_APU_CNT)-1:0]    new_stride_x_formula,
  input  logic [(2**LOG_LOOP_CNT+1)*BITS*(2**LOG_APU_CNT)-1:0]    new_stride_y_formula,
  input  logic [LOG_LOOP_CNT-1:0]                                 loop_var,
  input  logic [LOG_APU_CNT-1:0]                                  apu_selector,
  output logic [6*BITS-1:0]                                       out
);

  localparam int LOOP_CNT = 2**LOG_LOOP_CNT;
  localparam int APU_CNT  = 2**LOG_APU_CNT;
  localparam int SLICE    = formula_width(BITS, LOOP_CNT);

  logic [SLICE*APU_CNT-1:0] w_formula_bus [ACC_CNT];
  logic [BITS-1:0]          w_value       [ACC_CNT][APU_CNT];
  logic [BITS-1:0]          w_delta       [ACC_CNT][APU_CNT];

  assign w_formula_bus[ACC_ADDR]     = new_address_formula;
  assign w_formula_bus[ACC_STRIDE_X] = new_stride_x_formula;
  assign w_formula_bus[ACC_STRIDE_Y] = new_stride_y_formula;

  for (genvar k = 0; k < ACC_CNT; k++) begin : g_kind
    for (genvar a = 0; a < APU_CNT; a++) begin : g_apu
      // APU 0 occupies the most significant slice of each bus.
      apu_accum #(
        .BITS         (BITS),
        .LOG_LOOP_CNT (LOG_LOOP_CNT)
      ) u_accum (
        .clk        (clk),
        .rst        (reset),
        .i_enable   (enable),
        .i_di       (di),
        .i_loop_var (loop_var),
        .i_formula  (w_formula_bus[k][SLICE*(APU_CNT-1-a) +: SLICE]),
        .o_value    (w_value[k][a]),
        .o_delta    (w_delta[k][a])
      );
    end
  end

  // Purely combinational selection: a selector change shows without an edge.
  assign out = {w_value[ACC_ADDR][apu_selector],
                w_value[ACC_STRIDE_X][apu_selector],
                w_value[ACC_STRIDE_Y][apu_selector],
                w_delta[ACC_ADDR][apu_selector],
                w_delta[ACC_STRIDE_X][apu_selector],
                w_delta[ACC_STRIDE_Y][apu_selector]};

endmodule

// File: tb/tb_apu.sv
// -----------------------------------------------------------------------------
// tb_apu: scoreboard bench for the apu bank. The driver applies inputs shortly
// after a rising edge and pushes the expected output word computed by a
// reference model (integer arrays of formulas and offsets); the monitor pops
// each expectation 2 ns later and compares all six output fields.
// -----------------------------------------------------------------------------
module tb_apu;
  import apu_pkg::*;

  localparam int BITS         = 8;
  localparam int LOG_LOOP_CNT = 1;
  localparam int LOG_APU_CNT  = 1;
  localparam int LOOP_CNT     = 2**LOG_LOOP_CNT;
  localparam int APU_CNT      = 2**LOG_APU_CNT;
  localparam int SLICE        = (LOOP_CNT+1)*BITS;
  localparam int FW           = SLICE*APU_CNT;
  localparam int OW           = 6*BITS;

  // clock / reset
  logic                    clk = 1'b0;
  logic                    reset;
  logic                    enable;
  logic [BITS-1:0]         di;
  logic [FW-1:0]           new_address_formula;
  logic [FW-1:0]           new_stride_x_formula;
  logic [FW-1:0]           new_stride_y_formula;
  logic [LOG_LOOP_CNT-1:0] loop_var;
  logic [LOG_APU_CNT-1:0]  apu_selector;
  logic [OW-1:0]           out;

  always #5 clk = ~clk;

  apu #(
    .BITS         (BITS),
    .LOG_LOOP_CNT (LOG_LOOP_CNT),
    .LOG_APU_CNT  (LOG_APU_CNT)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .enable               (enable),
    .di                   (di),
    .new_address_formula  (new_address_formula),
    .new_stride_x_formula (new_stride_x_formula),
    .new_stride_y_formula (new_stride_y_formula),
    .loop_var             (loop_var),
    .apu_selector         (apu_selector),
    .out                  (out)
  );

  // reference model: [kind][apu][term], term 0 = base, 1+j = coef of loop j
  int unsigned n_form [3][APU_CNT][LOOP_CNT+1];  // driven on the new_* inputs
  int unsigned m_form [3][APU_CNT][LOOP_CNT+1];  // latched in the design
  int unsigned m_off  [3][APU_CNT];
  bit          m_valid = 1'b0;

  // scoreboard
  logic [OW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [OW-1:0] expect_out();
    logic [BITS-1:0] val [3];
    logic [BITS-1:0] dlt [3];
    int unsigned s = apu_selector;
    int unsigned l = loop_var;
    for (int k = 0; k < 3; k++) begin
      val[k] = BITS'((m_form[k][s][0] + m_off[k][s]) % 256);
      dlt[k] = BITS'((int'(di) * m_form[k][s][1+l]) % 256);
    end
    return {val[0], val[1], val[2], dlt[0], dlt[1], dlt[2]};
  endfunction

  task automatic drive_formulas();
    logic [FW-1:0] bus [3];
    for (int k = 0; k < 3; k++) begin
      bus[k] = '0;
      for (int a = 0; a < APU_CNT; a++)
        for (int t = 0; t <= LOOP_CNT; t++)
          bus[k][SLICE*(APU_CNT-1-a) + t*BITS +: BITS] = BITS'(n_form[k][a][t]);
    end
    new_address_formula  = bus[0];
    new_stride_x_formula = bus[1];
    new_stride_y_formula = bus[2];
  endtask

  task automatic random_formulas();
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < APU_CNT; a++)
        for (int t = 0; t <= LOOP_CNT; t++)
          n_form[k][a][t] = $urandom_range(0, 255);
    drive_formulas();
  endtask

  // apply inputs mid-cycle and queue the expected combinational output
  task automatic set_in(input logic r, input logic e, input logic [BITS-1:0] d,
                        input int l, input int s);
    reset        = r;
    enable       = e;
    di           = d;
    loop_var     = LOG_LOOP_CNT'(l);
    apu_selector = LOG_APU_CNT'(s);
    if (r) begin
      for (int k = 0; k < 3; k++)
        for (int a = 0; a < APU_CNT; a++) m_off[k][a] = 0;
    end
    if (m_valid) exp_q.push_back(expect_out());
    #3;
  endtask

  // advance the model across one rising edge using the inputs now applied
  task automatic clk_edge();
    @(posedge clk);
    if (reset) begin
      m_form  = n_form;
      m_valid = 1'b1;
      for (int k = 0; k < 3; k++)
        for (int a = 0; a < APU_CNT; a++) m_off[k][a] = 0;
    end else if (enable) begin
      for (int k = 0; k < 3; k++)
        for (int a = 0; a < APU_CNT; a++)
          m_off[k][a] = (m_off[k][a] + int'(di) * m_form[k][a][1+int'(loop_var)]) % 256;
    end
    #1;
  endtask

  task automatic step(input logic r, input logic e, input logic [BITS-1:0] d,
                      input int l, input int s);
    set_in(r, e, d, l, s);
    clk_edge();
  endtask

  // monitor
  string fname [6] = '{"addr", "stridex", "stridey", "daddr", "dstridex", "dstridey"};
  initial begin : monitor
    logic [OW-1:0] exp_v;
    logic [BITS-1:0] a_f, e_f;
    forever begin
      wait (exp_q.size() != 0);
      #2;
      exp_v = exp_q.pop_front();
      n_vec++;
      for (int f = 0; f < 6; f++) begin
        a_f = out[(5-f)*BITS +: BITS];
        e_f = exp_v[(5-f)*BITS +: BITS];
        if (a_f !== e_f) begin
          n_err++;
          $display("FAIL %s at %0t: got %0d expected %0d", fname[f], $time, a_f, e_f);
        end
      end
    end
  end

  // driver
  initial begin : driver
    reset = 1'b1; enable = 1'b1; di = '0; loop_var = '0; apu_selector = '0;
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < APU_CNT; a++) begin
        m_off[k][a] = 0;
        for (int t = 0; t <= LOOP_CNT; t++) begin
          n_form[k][a][t] = 0;
          m_form[k][a][t] = 0;
        end
      end
    // address: APU0 {0,1,2}, APU1 {0,3,4}; stride_x APU0 {5,1,1}
    n_form[0][0] = '{0, 1, 2};
    n_form[0][1] = '{0, 3, 4};
    n_form[1][0] = '{5, 1, 1};
    n_form[1][1] = '{$urandom_range(0,255), $urandom_range(0,255), $urandom_range(0,255)};
    n_form[2][0] = '{$urandom_range(0,255), $urandom_range(0,255), $urandom_range(0,255)};
    n_form[2][1] = '{$urandom_range(0,255), $urandom_range(0,255), $urandom_range(0,255)};
    drive_formulas();
    #1;

    // reset load, then check bases while reset still high
    step(1'b1, 1'b1, 8'd0, 0, 0);
    set_in(1'b1, 1'b1, 8'd0, 0, 1);
    set_in(1'b1, 1'b1, 8'd0, 0, 0);
    clk_edge();
    // single step, hold, step loop 0, switch loop var, negative step
    step(1'b0, 1'b1, 8'd1, 0, 0);
    step(1'b0, 1'b1, 8'd0, 0, 0);
    step(1'b0, 1'b1, 8'd2, 0, 0);
    step(1'b0, 1'b1, 8'd2, 1, 0);
    step(1'b0, 1'b1, 8'hFE, 1, 0);
    // selector change without an edge
    set_in(1'b0, 1'b1, 8'd0, 1, 0);
    set_in(1'b0, 1'b1, 8'd0, 1, 1);
    clk_edge();
    // enable low holds
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'd5, i % 2, i % 2);
    // mid-run reset clears offsets at once, reload new formulas at the edge
    step(1'b0, 1'b1, 8'd3, 1, 0);
    random_formulas();
    set_in(1'b1, 1'b0, 8'd5, 0, 0);
    set_in(1'b1, 1'b0, 8'd5, 0, 1);
    clk_edge();
    set_in(1'b1, 1'b1, 8'd7, 1, 0);
    clk_edge();

    // randomized phase
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        random_formulas();
        step(1'b1, 1'($urandom_range(0, 1)), BITS'($urandom_range(0, 255)),
             $urandom_range(0, LOOP_CNT-1), $urandom_range(0, APU_CNT-1));
      end else begin
        if ($urandom_range(0, 7) == 0)
          set_in(1'b0, 1'b1, BITS'($urandom_range(0, 255)),
                 $urandom_range(0, LOOP_CNT-1), $urandom_range(0, APU_CNT-1));
        step(1'b0, ($urandom_range(0, 3) != 0), BITS'($urandom_range(0, 255)),
             $urandom_range(0, LOOP_CNT-1), $urandom_range(0, APU_CNT-1));
      end
    end

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
